apb_master: RTL and testbench

// - APB requester: turns a local valid/ready command into one APB transfer to
//   one of two slaves (slave1, slave2), then returns a one-cycle response.
// - Sits between the system controller and the slave1/slave2 bus ports.
// - Drives paddr/pwdata/pwrite/penable and one psel per slave.
// - Muxes pready/prdata back from the selected slave.

---
 rtl/apb_master.sv | 183 ++++++++++++++++++
 tb/tb_apb_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one APB transfer to slave1 or slave2.
// Define APB_MASTER_TIMEOUT_EN to bound the ACCESS wait at TIMEOUT cycles.
module apb_master #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_tmo,
    output logic [AW-2:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic          pwrite,
    output logic          penable,
    output logic          psel1,
    output logic          psel2,
    input  logic          pready1,
    input  logic          pready2,
    input  logic [DW-1:0] prdata1,
    input  logic [DW-1:0] prdata2
);

    generate
        if (TIMEOUT < 2 || AW < 2) begin : g_bad_params
            $error("apb_master: TIMEOUT must be >= 2 and AW must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic          slave_sel;
    logic          accept;
    logic          sel_ready;
    logic          tmo_hit;
    logic          done;
    logic [DW-1:0] sel_rdata;

    logic          cmd_ready_nxt;
    logic          rsp_valid_nxt;
    logic [DW-1:0] rsp_rdata_nxt;
    logic          rsp_tmo_nxt;
    logic [AW-2:0] paddr_nxt;
    logic [DW-1:0] pwdata_nxt;
    logic          pwrite_nxt;
    logic          penable_nxt;
    logic          psel1_nxt;
    logic          psel2_nxt;
    logic          slave_sel_nxt;

    // Only the selected slave's handshake and data are ever looked at.
    assign accept    = cmd_valid && cmd_ready;
    assign sel_ready = slave_sel ? pready2 : pready1;
    assign sel_rdata = slave_sel ? prdata2 : prdata1;
    assign done      = (state == ACCESS) && (sel_ready || tmo_hit);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] acc_cnt;

    always_ff @(posedge pclk) begin
        if (preset) begin
            acc_cnt <= '0;
        end else if (state == SETUP) begin
            acc_cnt <= '0;
        end else if (state == ACCESS) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    // A ready on the final counted cycle still wins over the abort.
    assign tmo_hit = (state == ACCESS) && !sel_ready && (acc_cnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        pwrite_nxt    = pwrite;
        penable_nxt   = penable;
        psel1_nxt     = psel1;
        psel2_nxt     = psel2;
        slave_sel_nxt = slave_sel;
        rsp_rdata_nxt = rsp_rdata;
        rsp_valid_nxt = 1'b0;
        rsp_tmo_nxt   = 1'b0;
        cmd_ready_nxt = (next_state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    paddr_nxt     = cmd_addr[AW-2:0];
                    pwdata_nxt    = cmd_wdata;
                    pwrite_nxt    = cmd_write;
                    slave_sel_nxt = cmd_addr[AW-1];
                    psel1_nxt     = !cmd_addr[AW-1];
                    psel2_nxt     = cmd_addr[AW-1];
                    penable_nxt   = 1'b0;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (done) begin
                    psel1_nxt     = 1'b0;
                    psel2_nxt     = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_tmo_nxt   = !sel_ready;
                    rsp_rdata_nxt = (pwrite || !sel_ready) ? '0 : sel_rdata;
                end
            end
            default: begin
                psel1_nxt   = 1'b0;
                psel2_nxt   = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // Address/data/direction intentionally survive reset-free idle periods.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_tmo   <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            psel1     <= 1'b0;
            psel2     <= 1'b0;
            slave_sel <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_tmo   <= rsp_tmo_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            pwrite    <= pwrite_nxt;
            penable   <= penable_nxt;
            psel1     <= psel1_nxt;
            psel2     <= psel2_nxt;
            slave_sel <= slave_sel_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: two behavioural APB slaves with programmable wait states,
// a queue of expected responses and a negedge monitor that checks APB phases and responses.
module tb_apb_master;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [8:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_tmo;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pwrite;
    logic       penable;
    logic       psel1;
    logic       psel2;
    logic       pready1;
    logic       pready2;
    logic [7:0] prdata1 = '0;
    logic [7:0] prdata2 = '0;

    apb_master #(.AW(9), .DW(8), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_tmo(rsp_tmo),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
        .psel1(psel1), .psel2(psel2), .pready1(pready1), .pready2(pready2),
        .prdata1(prdata1), .prdata2(prdata2)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] wdata;
        logic       write;
        logic [7:0] rdata;
        logic       tmo;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    // Slave models: pready registered one cycle after psel&&penable, plus stall cycles.
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic p1_r = 1'b0, p2_r = 1'b0;
    int   cnt1 = 0, cnt2 = 0;
    int   stall1 = 0, stall2 = 0;
    logic hang1 = 1'b0, hang2 = 1'b0, noise2 = 1'b0;

    assign pready1 = p1_r;
    assign pready2 = p2_r | noise2;

    always @(posedge pclk) begin
        if (psel1 && penable && !p1_r) begin
            if (!hang1 && cnt1 >= stall1) begin
                p1_r <= 1'b1;
                if (pwrite) mem1[paddr] <= pwdata;
                else prdata1 <= mem1[paddr];
            end else begin
                cnt1 <= cnt1 + 1;
            end
        end else begin
            p1_r <= 1'b0;
            cnt1 <= 0;
        end
    end

    always @(posedge pclk) begin
        if (psel2 && penable && !p2_r) begin
            if (!hang2 && cnt2 >= stall2) begin
                p2_r <= 1'b1;
                if (pwrite) mem2[paddr] <= pwdata;
                else prdata2 <= mem2[paddr];
            end else begin
                cnt2 <= cnt2 + 1;
            end
        end else begin
            p2_r <= 1'b0;
            cnt2 <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flagFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got event expected none or got nothing expected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: APB phase checks every selected cycle, response checks on rsp_valid.
    exp_t mon_e;
    int   psel_cnt = 0;
    int   acc_edge_m;

    always @(negedge pclk) begin
        if (preset) begin
            exp_q.delete();
            acc_q.delete();
            psel_cnt = 0;
        end else begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
            if (psel1 || psel2) begin
                if (exp_q.size() == 0) begin
                    flagFail("unexpected_psel");
                end else begin
                    mon_e = exp_q[0];
                    checkOutput("psel_onehot", {30'd0, psel2, psel1}, mon_e.addr[8] ? 32'd2 : 32'd1);
                    checkOutput("paddr", {24'd0, paddr}, {24'd0, mon_e.addr[7:0]});
                    checkOutput("pwrite", {31'd0, pwrite}, {31'd0, mon_e.write});
                    if (mon_e.write) checkOutput("pwdata", {24'd0, pwdata}, {24'd0, mon_e.wdata});
                    checkOutput("penable_phase", {31'd0, penable}, (psel_cnt != 0) ? 32'd1 : 32'd0);
                end
                psel_cnt++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    flagFail("unexpected_rsp");
                end else begin
                    mon_e = exp_q.pop_front();
                    acc_edge_m = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_e.rdata});
                    checkOutput("rsp_tmo", {31'd0, rsp_tmo}, {31'd0, mon_e.tmo});
                    checkOutput("rsp_latency", cyc - acc_edge_m, mon_e.lat);
                    checkOutput("psel_cycles", psel_cnt, mon_e.lat);
                end
                psel_cnt = 0;
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [8:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata, input logic exp_tmo, input int exp_lat,
                                 output int acc_edge);
        exp_t e;
        e.addr = addr;
        e.wdata = wdata;
        e.write = wr;
        e.rdata = exp_rdata;
        e.tmo = exp_tmo;
        e.lat = exp_lat;
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr = addr;
        cmd_wdata = wdata;
        acc_edge = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (cmd_ready) begin
                @(posedge pclk);
                #1;
                acc_edge = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc_edge < 0) flagFail("accept_timeout");
    endtask

    task automatic waitDone();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge pclk);
        #1;
        if (exp_q.size() != 0) flagFail("response_timeout");
    endtask

    int a0, a1;

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_psel", {30'd0, psel2, psel1}, 32'd0);
        checkOutput("reset_penable", {31'd0, penable}, 32'd0);
        checkOutput("reset_rsp_tmo", {31'd0, rsp_tmo}, 32'd0);
        checkOutput("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        checkOutput("reset_paddr", {24'd0, paddr}, 32'd0);
        preset = 1'b0;
        @(posedge pclk);
        #1;

        applyStimulus(1'b1, 9'h0A5, 8'h3C, 8'h00, 1'b0, 3, a0);
        waitDone();
        applyStimulus(1'b1, 9'h1A5, 8'h77, 8'h00, 1'b0, 3, a0);
        waitDone();
        applyStimulus(1'b0, 9'h1A5, 8'h00, 8'h77, 1'b0, 3, a0);
        waitDone();
        applyStimulus(1'b0, 9'h0A5, 8'h00, 8'h3C, 1'b0, 3, a0);
        waitDone();

        stall1 = 2;
        applyStimulus(1'b1, 9'h010, 8'hC3, 8'h00, 1'b0, 5, a0);
        waitDone();
        applyStimulus(1'b0, 9'h010, 8'h00, 8'hC3, 1'b0, 5, a0);
        waitDone();
        stall1 = 0;

        stall2 = 4;
        applyStimulus(1'b0, 9'h1A5, 8'h00, 8'h77, 1'b0, 7, a0);
        waitDone();
        stall2 = 0;

        noise2 = 1'b1;
        stall1 = 3;
        applyStimulus(1'b0, 9'h0A5, 8'h00, 8'h3C, 1'b0, 6, a0);
        waitDone();
        noise2 = 1'b0;
        stall1 = 0;

        applyStimulus(1'b1, 9'h1FF, 8'hAA, 8'h00, 1'b0, 3, a0);
        applyStimulus(1'b0, 9'h1FF, 8'h00, 8'hAA, 1'b0, 3, a1);
        checkOutput("b2b_spacing", a1 - a0, 32'd4);
        waitDone();

        hang2 = 1'b1;
        applyStimulus(1'b0, 9'h1A5, 8'h00, 8'h77, 1'b0, 3, a0);
        repeat (4) @(posedge pclk);
        #1;
        preset = 1'b1;
        @(posedge pclk);
        #1;
        preset = 1'b0;
        checkOutput("midreset_psel", {30'd0, psel2, psel1}, 32'd0);
        checkOutput("midreset_penable", {31'd0, penable}, 32'd0);
        checkOutput("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        hang2 = 1'b0;
        repeat (6) @(posedge pclk);
        #1;

        applyStimulus(1'b0, 9'h0A5, 8'h00, 8'h3C, 1'b0, 3, a0);
        waitDone();

`ifdef APB_MASTER_TIMEOUT_EN
        hang1 = 1'b1;
        applyStimulus(1'b0, 9'h033, 8'h00, 8'h00, 1'b1, 17, a0);
        waitDone();
        hang1 = 1'b0;
        applyStimulus(1'b0, 9'h010, 8'h00, 8'hC3, 1'b0, 3, a0);
        waitDone();
`endif

        repeat (3) @(posedge pclk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
